// File: rtl/sram_responder.sv
// sram_responder: windowed word RAM with fixed read latency, sticky error flags and write counter
module sram_responder #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h1c000000,
  parameter int          RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        err_clr,
  output logic        err_mis,
  output logic        err_oob,
  output logic [31:0] wr_cnt
);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("sram_responder: RD_LAT must be in 1..4");
  end
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       pipe [RD_LAT];
  logic              in_win;
  logic              wr_ok;
  logic              mis_new;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_val;
  // decode the address and form the write-first read value
  always_comb begin
    in_win  = sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2];
    idx     = sram_addr[ADDR_W+1:2];
    wr_ok   = sram_we && in_win && sram_addr[1:0] == 2'b00;
    mis_new = sram_we && in_win && sram_addr[1:0] != 2'b00;
    rd_val  = !in_win ? 32'h0 : wr_ok ? sram_wdata : mem[idx];
  end
  // RAM array is never reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[idx] <= sram_wdata;
  end
  // read pipeline: one stage per cycle of latency, advancing every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_val;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sram_rdata = pipe[RD_LAT-1];
  // sticky error flags (a new error beats a clear) and saturating write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_mis <= 1'b0;
      err_oob <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      err_mis <= mis_new || (err_mis && !err_clr);
      err_oob <= !in_win || (err_oob && !err_clr);
      wr_cnt  <= wr_cnt + 32'(wr_ok && wr_cnt != '1);
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: table-driven and scoreboard checks of two responders (RD_LAT 1 and 3)
module tb_sram_responder;
  localparam logic [31:0] BASE = 32'h1c000000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_we = 1'b0;
  logic [31:0] sram_addr = BASE;
  logic [31:0] sram_wdata = '0;
  logic        err_clr = 1'b0;
  logic [31:0] rd1, rd3, cnt1, cnt3;
  logic        mis1, mis3, oob1, oob3;
  int          tests = 0;
  int          fails = 0;
  typedef struct {logic [31:0] d; bit chk;} exp_t;
  typedef struct {logic we; logic [31:0] a; logic [31:0] wd; logic clr; logic mis; logic oob; logic [31:0] cnt;} vec_t;
  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] mm [4096];
  bit          mv [4096];
  vec_t        tbl [21];

  sram_responder #(.ADDR_W(12), .BASE(BASE), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(rd1), .err_clr(err_clr), .err_mis(mis1), .err_oob(oob1), .wr_cnt(cnt1));
  sram_responder #(.ADDR_W(12), .BASE(BASE), .RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(rd3), .err_clr(err_clr), .err_mis(mis3), .err_oob(oob3), .wr_cnt(cnt3));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic restart_queues();
    exp_t z;
    z.d = '0;
    z.chk = 1'b1;
    q1.delete();
    q3.delete();
    repeat (2) q3.push_back(z);
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic clr);
    exp_t       e;
    logic [11:0] ix;
    logic       win, ok;
    sram_we = we;
    sram_addr = a;
    sram_wdata = wd;
    err_clr = clr;
    win = a[31:14] == BASE[31:14];
    ix = a[13:2];
    ok = we && win && a[1:0] == 2'b00;
    e.d = !win ? 32'h0 : ok ? wd : mm[ix];
    e.chk = !win || ok || mv[ix];
    if (ok) begin
      mm[ix] = wd;
      mv[ix] = 1'b1;
    end
    q1.push_back(e);
    q3.push_back(e);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    if (e.chk) chk("rdata_lat1", rd1, e.d);
    e = q3.pop_front();
    if (e.chk) chk("rdata_lat3", rd3, e.d);
  endtask

  task automatic chk_state(input string name, input logic mis, input logic oob, input logic [31:0] cnt);
    chk({name, "_mis1"}, 32'(mis1), 32'(mis));
    chk({name, "_mis3"}, 32'(mis3), 32'(mis));
    chk({name, "_oob1"}, 32'(oob1), 32'(oob));
    chk({name, "_oob3"}, 32'(oob3), 32'(oob));
    chk({name, "_cnt1"}, cnt1, cnt);
    chk({name, "_cnt3"}, cnt3, cnt);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h1c000010, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[1]  = '{1'b0, 32'h1c000010, 32'h0,        1'b0, 1'b0, 1'b0, 32'd1};
    tbl[2]  = '{1'b1, 32'h1c000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[3]  = '{1'b1, 32'h1c000000, 32'd1,        1'b0, 1'b0, 1'b0, 32'd3};
    tbl[4]  = '{1'b1, 32'h1c000004, 32'd2,        1'b0, 1'b0, 1'b0, 32'd4};
    tbl[5]  = '{1'b1, 32'h1c000008, 32'd3,        1'b0, 1'b0, 1'b0, 32'd5};
    tbl[6]  = '{1'b0, 32'h1c000000, 32'h0,        1'b0, 1'b0, 1'b0, 32'd5};
    tbl[7]  = '{1'b0, 32'h1c000004, 32'h0,        1'b0, 1'b0, 1'b0, 32'd5};
    tbl[8]  = '{1'b1, 32'h1c000004, 32'd9,        1'b0, 1'b0, 1'b0, 32'd6};
    tbl[9]  = '{1'b0, 32'h1c000008, 32'h0,        1'b0, 1'b0, 1'b0, 32'd6};
    tbl[10] = '{1'b0, 32'h1c000004, 32'h0,        1'b0, 1'b0, 1'b0, 32'd6};
    tbl[11] = '{1'b1, 32'h1c000006, 32'haaaaaaaa, 1'b0, 1'b1, 1'b0, 32'd6};
    tbl[12] = '{1'b0, 32'h1c000004, 32'h0,        1'b0, 1'b1, 1'b0, 32'd6};
    tbl[13] = '{1'b0, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b1, 32'd6};
    tbl[14] = '{1'b1, 32'h1c000006, 32'd5,        1'b1, 1'b1, 1'b0, 32'd6};
    tbl[15] = '{1'b0, 32'h1c000000, 32'h0,        1'b1, 1'b0, 1'b0, 32'd6};
    tbl[16] = '{1'b1, 32'h00000002, 32'd7,        1'b0, 1'b0, 1'b1, 32'd6};
    tbl[17] = '{1'b0, 32'h1c000000, 32'h0,        1'b1, 1'b0, 1'b0, 32'd6};
    tbl[18] = '{1'b1, 32'h1c003ffc, 32'hcafef00d, 1'b0, 1'b0, 1'b0, 32'd7};
    tbl[19] = '{1'b0, 32'h1c004000, 32'h0,        1'b0, 1'b0, 1'b1, 32'd7};
    tbl[20] = '{1'b0, 32'h1c003ffc, 32'h0,        1'b1, 1'b0, 1'b0, 32'd7};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rd3", rd3, 32'h0);
    chk_state("reset", 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    restart_queues();
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].clr);
      chk_state($sformatf("vec%0d", i), tbl[i].mis, tbl[i].oob, tbl[i].cnt);
    end
    step(1'b0, 32'h00000000, 32'h0, 1'b0);
    step(1'b0, 32'h1c000000, 32'h0, 1'b0);
    step(1'b0, 32'h1c000004, 32'h0, 1'b0);
    step(1'b1, 32'h1c000006, 32'h0, 1'b0);
    chk_state("pre_reset", 1'b1, 1'b1, 32'd7);
    sram_we = 1'b1;
    sram_addr = 32'h1c000000;
    sram_wdata = 32'hffffffff;
    err_clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midreset_rd1", rd1, 32'h0);
    chk("midreset_rd3", rd3, 32'h0);
    chk_state("midreset", 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    chk_state("held_reset", 1'b0, 1'b0, 32'd0);
    sram_we = 1'b0;
    sram_addr = BASE;
    reset = 1'b0;
    restart_queues();
    step(1'b0, 32'h1c000000, 32'h0, 1'b0);
    step(1'b0, 32'h1c003ffc, 32'h0, 1'b0);
    step(1'b0, 32'h1c000010, 32'h0, 1'b0);
    step(1'b0, 32'h1c000008, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h1c000000, 32'h0, 1'b0);
    chk_state("post_reset", 1'b0, 1'b0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
